// File: rtl/dbg_ram_bridge.sv
// -----------------------------------------------------------------------------
// dbg_ram_bridge
//   Single-port, word-wide debug RAM (debug ROM / scratch) behind the debug
//   region of the memory mux. Core instruction and data requests share one
//   array through a req/gnt/rvalid handshake. A debugger preload port has top
//   priority over both core ports.
//
//   Optional feature macro: DBG_RAM_ROUND_ROBIN_EN
//     defined   : round-robin between instr and data on a core conflict
//                 (the port not granted most recently wins; instr goes first
//                 after reset).
//     undefined : fixed priority, data over instr; no arbiter pointer flop.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   instr_req_i/gnt_o/rvalid_o    instruction fetch handshake (read only)
//   instr_addr_i, instr_rdata_o   instruction byte address / read data
//   data_req_i/gnt_o/rvalid_o     data handshake
//   data_we_i, data_be_i          write enable, byte enables
//   data_addr_i, data_wdata_i     data byte address / write data
//   data_rdata_o                  data read data (0 for write responses)
//   load_we_i/addr_i/wdata_i      debugger full-word preload port
// -----------------------------------------------------------------------------
module dbg_ram_bridge #(
    parameter  int DEPTH  = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              instr_req_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    input  logic [31:0]       instr_addr_i,
    output logic [31:0]       instr_rdata_o,
    input  logic              data_req_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    input  logic              data_we_i,
    input  logic [3:0]        data_be_i,
    input  logic [31:0]       data_addr_i,
    input  logic [31:0]       data_wdata_i,
    output logic [31:0]       data_rdata_o,
    input  logic              load_we_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [31:0]       load_wdata_i
);

    logic [31:0] mem [DEPTH];

    logic [ADDR_W-1:0] instr_idx;
    logic [ADDR_W-1:0] data_idx;
    logic              instr_gnt;
    logic              data_gnt;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_idx;
    logic [31:0]       wr_data;
    logic [3:0]        wr_be;
    logic [ADDR_W-1:0] rd_idx;

    logic              instr_rvalid_reg;
    logic              data_rvalid_reg;
    logic [31:0]       instr_rdata_reg;
    logic [31:0]       data_rdata_reg;

    // Byte-offset bits and bits above the array are ignored, so addresses
    // beyond DEPTH alias onto the array.
    assign instr_idx = instr_addr_i[ADDR_W+1:2];
    assign data_idx  = data_addr_i[ADDR_W+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{instr_addr_i[31:ADDR_W+2], instr_addr_i[1:0],
                                data_addr_i[31:ADDR_W+2],  data_addr_i[1:0]};

`ifdef DBG_RAM_ROUND_ROBIN_EN
    // 1 = data was the most recent core grant. Reset to 1 so instr wins the
    // first conflict.
    logic last_data_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_data_reg <= 1'b1;
        end else if (instr_gnt || data_gnt) begin
            last_data_reg <= data_gnt;
        end
    end
`endif

    // Grant logic: nothing while in reset or while the preload port owns the
    // array this cycle; otherwise one core port.
    always_comb begin
        instr_gnt = 1'b0;
        data_gnt  = 1'b0;
        if (!rst_i && !load_we_i) begin
            if (instr_req_i && data_req_i) begin
`ifdef DBG_RAM_ROUND_ROBIN_EN
                if (last_data_reg) begin
                    instr_gnt = 1'b1;
                end else begin
                    data_gnt = 1'b1;
                end
`else
                data_gnt = 1'b1;
`endif
            end else begin
                instr_gnt = instr_req_i;
                data_gnt  = data_req_i;
            end
        end
    end

    // Single array access per cycle: preload write, core write or core read.
    always_comb begin
        wr_en   = load_we_i | (data_gnt & data_we_i);
        wr_idx  = data_idx;
        wr_data = data_wdata_i;
        wr_be   = data_be_i;
        if (load_we_i) begin
            wr_idx  = load_addr_i;
            wr_data = load_wdata_i;
            wr_be   = 4'hF;
        end
        rd_idx = data_gnt ? data_idx : instr_idx;
    end

    // Array write with per-byte enables; contents are never reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Registered read and response flags. rdata holds between responses;
    // a data write answers with zero data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_rvalid_reg <= 1'b0;
            data_rvalid_reg  <= 1'b0;
            instr_rdata_reg  <= 32'h0;
            data_rdata_reg   <= 32'h0;
        end else begin
            instr_rvalid_reg <= instr_gnt;
            data_rvalid_reg  <= data_gnt;
            if (instr_gnt) begin
                instr_rdata_reg <= mem[rd_idx];
            end
            if (data_gnt) begin
                data_rdata_reg <= data_we_i ? 32'h0 : mem[rd_idx];
            end
        end
    end

    assign instr_gnt_o    = instr_gnt;
    assign data_gnt_o     = data_gnt;
    assign instr_rvalid_o = instr_rvalid_reg;
    assign data_rvalid_o  = data_rvalid_reg;
    assign instr_rdata_o  = instr_rdata_reg;
    assign data_rdata_o   = data_rdata_reg;

endmodule

// File: tb/tb_dbg_ram_bridge.sv
// -----------------------------------------------------------------------------
// tb_dbg_ram_bridge
//   Directed stimulus with hand-computed expectations. The stimulus process
//   checks grants and pushes expected responses into per-port queues; a
//   monitor pops and compares whenever the DUT raises rvalid.
// -----------------------------------------------------------------------------
module tb_dbg_ram_bridge;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst;
    logic              instr_req, instr_gnt, instr_rvalid;
    logic [31:0]       instr_addr, instr_rdata;
    logic              data_req, data_gnt, data_rvalid, data_we;
    logic [3:0]        data_be;
    logic [31:0]       data_addr, data_wdata, data_rdata;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_wdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dbg_ram_bridge #(.DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .instr_req_i   (instr_req),
        .instr_gnt_o   (instr_gnt),
        .instr_rvalid_o(instr_rvalid),
        .instr_addr_i  (instr_addr),
        .instr_rdata_o (instr_rdata),
        .data_req_i    (data_req),
        .data_gnt_o    (data_gnt),
        .data_rvalid_o (data_rvalid),
        .data_we_i     (data_we),
        .data_be_i     (data_be),
        .data_addr_i   (data_addr),
        .data_wdata_i  (data_wdata),
        .data_rdata_o  (data_rdata),
        .load_we_i     (load_we),
        .load_addr_i   (load_addr),
        .load_wdata_i  (load_wdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every response against the queue head, including its
    // due cycle; flag spurious and missing responses.
    always @(negedge clk) begin
        if (iq.size() > 0 && iq[0].due < cyc) begin
            checks++; errors++;
            $display("FAIL instr_missing: got no rvalid expected %08h due cycle %0d", iq[0].d, iq[0].due);
            void'(iq.pop_front());
        end
        if (dq.size() > 0 && dq[0].due < cyc) begin
            checks++; errors++;
            $display("FAIL data_missing: got no rvalid expected %08h due cycle %0d", dq[0].d, dq[0].due);
            void'(dq.pop_front());
        end
        if (instr_rvalid === 1'b1) begin
            if (iq.size() == 0) begin
                checks++; errors++;
                $display("FAIL instr_spurious: got rvalid rdata %08h expected none (cycle %0d)", instr_rdata, cyc);
            end else begin
                exp_t e;
                e = iq.pop_front();
                chk("instr_rdata", instr_rdata, e.d);
                chk("instr_latency", cyc, e.due);
                $display("RSP instr rdata=%08h exp=%08h cycle=%0d", instr_rdata, e.d, cyc);
            end
        end
        if (data_rvalid === 1'b1) begin
            if (dq.size() == 0) begin
                checks++; errors++;
                $display("FAIL data_spurious: got rvalid rdata %08h expected none (cycle %0d)", data_rdata, cyc);
            end else begin
                exp_t e;
                e = dq.pop_front();
                chk("data_rdata", data_rdata, e.d);
                chk("data_latency", cyc, e.due);
                $display("RSP data  rdata=%08h exp=%08h cycle=%0d", data_rdata, e.d, cyc);
            end
        end
    end

    // One cycle of stimulus, entered 1 time unit after a rising edge.
    task automatic step(
        input string             name,
        input logic              ireq, input logic [31:0] iaddr,
        input logic              dreq, input logic dwe, input logic [3:0] dbe,
        input logic [31:0]       daddr, input logic [31:0] dwdata,
        input logic              lwe, input logic [ADDR_W-1:0] laddr,
        input logic [31:0]       lwdata,
        input logic              exp_ig, input logic exp_dg,
        input logic [31:0]       exp_ird, input logic [31:0] exp_drd
    );
        exp_t e;
        instr_req = ireq; instr_addr = iaddr;
        data_req = dreq; data_we = dwe; data_be = dbe;
        data_addr = daddr; data_wdata = dwdata;
        load_we = lwe; load_addr = laddr; load_wdata = lwdata;
        @(negedge clk);
        chk({name, ".instr_gnt"}, {31'h0, instr_gnt}, {31'h0, exp_ig});
        chk({name, ".data_gnt"},  {31'h0, data_gnt},  {31'h0, exp_dg});
        $display("TXN %s ireq=%0b dreq=%0b we=%0b lwe=%0b gnt i/d=%0b/%0b exp %0b/%0b",
                 name, ireq, dreq, dwe, lwe, instr_gnt, data_gnt, exp_ig, exp_dg);
        if (exp_ig) begin e.d = exp_ird; e.due = cyc + 1; iq.push_back(e); end
        if (exp_dg) begin e.d = exp_drd; e.due = cyc + 1; dq.push_back(e); end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string name);
        step(name, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

`ifdef DBG_RAM_ROUND_ROBIN_EN
    localparam logic [2:0] CONF_IG = 3'b101;
`else
    localparam logic [2:0] CONF_IG = 3'b000;
`endif

    initial begin
        rst = 1'b1;
        instr_req = 0; instr_addr = 0;
        data_req = 0; data_we = 0; data_be = 0; data_addr = 0; data_wdata = 0;
        load_we = 0; load_addr = 0; load_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset.instr_rvalid", {31'h0, instr_rvalid}, 32'h0);
        chk("reset.data_rvalid",  {31'h0, data_rvalid},  32'h0);
        chk("reset.instr_rdata",  instr_rdata, 32'h0);
        chk("reset.data_rdata",   data_rdata,  32'h0);
        @(posedge clk);
        #1;

        // 1: preload words 0..3 (plus word 4 = all ones), instr fetch of word 2
        for (int i = 0; i < 4; i++)
            step("load", 0, 0, 0, 0, 4'h0, 0, 0, 1, ADDR_W'(i), 32'hA0 + i, 0, 0, 0, 0);
        step("load4", 0, 0, 0, 0, 4'h0, 0, 0, 1, ADDR_W'(4), 32'hFFFF_FFFF, 0, 0, 0, 0);
        step("ifetch_w2", 1, 32'h2000_0008, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 32'hA2, 0);

        // 2: partial write to word 4, read back on both ports
        step("dwr_be5", 0, 0, 1, 1, 4'b0101, 32'h2000_0010, 32'h1122_3344, 0, 0, 0, 0, 1, 0, 32'h0);
        step("ird_w4",  1, 32'h2000_0010, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 32'hFF22_FF44, 0);
        step("drd_w4",  0, 0, 1, 0, 4'h0, 32'h2000_0010, 0, 0, 0, 0, 0, 1, 0, 32'hFF22_FF44);

        // 3: three-cycle conflict, instr word 0 vs data word 1
        for (int i = 0; i < 3; i++)
            step("conflict", 1, 32'h2000_0000, 1, 0, 4'h0, 32'h2000_0004, 0, 0, 0, 0,
                 CONF_IG[i], !CONF_IG[i], 32'hA0, 32'hA1);

        // 4: preload beats both core requests; core served the next cycle
        step("load_blk", 1, 32'h2000_0000, 1, 0, 4'h0, 32'h2000_0018, 0, 1, ADDR_W'(6), 32'h66, 0, 0, 0, 0);
        step("after_ld", 1, 32'h2000_0000, 1, 0, 4'h0, 32'h2000_0018, 0, 0, 0, 0, 0, 1, 0, 32'h66);
        step("i_alone",  1, 32'h2000_0000, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 32'hA0, 0);

        // 5: write-then-read forwarding, aliasing, empty byte-enable write
        step("dwr_w5",   0, 0, 1, 1, 4'hF, 32'h2000_0014, 32'hDEAD_BEEF, 0, 0, 0, 0, 1, 0, 32'h0);
        step("drd_alias", 0, 0, 1, 0, 4'h0, DEPTH * 4 + 20, 0, 0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF);
        step("dwr_be0",  0, 0, 1, 1, 4'h0, 32'h2000_0014, 32'h0BAD_F00D, 0, 0, 0, 0, 1, 0, 32'h0);
        step("ird_w5",   1, 32'h2000_0014, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 0);
        step("drd_w3",   0, 0, 1, 0, 4'h0, 32'h2000_000C, 0, 0, 0, 0, 0, 1, 0, 32'hA3);

        // 6: reset right after a grant; requests held during reset get nothing
        step("pre_rst",  1, 32'h2000_0004, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 32'hA1, 0);
        rst = 1'b1;
        step("in_rst0",  1, 32'h2000_0004, 1, 0, 4'h0, 32'h2000_0004, 0, 0, 0, 0, 0, 0, 0, 0);
        step("in_rst1",  1, 32'h2000_0004, 1, 0, 4'h0, 32'h2000_0004, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        instr_req = 0; data_req = 0;
        @(negedge clk);
        chk("post_rst.instr_rvalid", {31'h0, instr_rvalid}, 32'h0);
        chk("post_rst.data_rvalid",  {31'h0, data_rvalid},  32'h0);
        chk("post_rst.instr_rdata",  instr_rdata, 32'h0);
        chk("post_rst.data_rdata",   data_rdata,  32'h0);
        @(posedge clk);
        #1;
        idle("idle0");
        idle("idle1");
        idle("idle2");

        chk("instr_queue_empty", iq.size(), 32'h0);
        chk("data_queue_empty",  dq.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
